// File: rtl/egg_timer_ctrl.sv
// Egg-timer countdown controller: button-edited duration, start/pause countdown
// in whole seconds from a clock prescaler, and a timed alarm at zero.
module egg_timer_ctrl #(
    parameter int TICK_DIV   = 100_000_000,
    parameter int MAX_COUNT  = 3599,
    parameter int ALARM_SECS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_min,
    input  logic        btn_sec,
    input  logic        btn_clr,
    output logic [11:0] count,
    output logic        running,
    output logic        alarm,
    output logic        tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);
    localparam logic [12:0]   MAX_C      = 13'(MAX_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

    state_t        state, state_n;
    logic [11:0]   count_n;
    logic [PW-1:0] presc, presc_n;
    logic [AW-1:0] acnt, acnt_n;
    logic          tick_n;
    logic          wrap;

    // 13-bit add so the carry past MAX_COUNT is visible before clamping
    function automatic logic [11:0] sat_add(input logic [11:0] c, input logic [6:0] inc);
        logic [12:0] sum;
        sum = {1'b0, c} + {6'd0, inc};
        return (sum > MAX_C) ? MAX_C[11:0] : sum[11:0];
    endfunction

    assign wrap = (presc == PRE_LAST);

    always_comb begin
        state_n = state;
        count_n = count;
        presc_n = presc;
        acnt_n  = acnt;
        tick_n  = 1'b0;
        case (state)
            IDLE, PAUSE: begin
                if (btn_clr) begin
                    count_n = '0;
                    presc_n = '0;
                    state_n = IDLE;
                end else if (btn_start) begin
                    // Resuming from PAUSE keeps the partial second already counted
                    if (count != '0) begin
                        state_n = RUN;
                        if (state == IDLE)
                            presc_n = '0;
                    end
                end else if (btn_min) begin
                    count_n = sat_add(count, 7'd60);
                end else if (btn_sec) begin
                    count_n = sat_add(count, 7'd1);
                end
            end
            RUN: begin
                if (btn_clr) begin
                    count_n = '0;
                    presc_n = '0;
                    state_n = IDLE;
                end else if (btn_start) begin
                    state_n = PAUSE;
                end else if (wrap) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    if (count <= 12'd1) begin
                        count_n = '0;
                        acnt_n  = '0;
                        state_n = ALARM;
                    end else begin
                        count_n = count - 12'd1;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            ALARM: begin
                count_n = '0;
                if (btn_clr || btn_start || btn_min || btn_sec) begin
                    presc_n = '0;
                    state_n = IDLE;
                end else if (wrap) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    if (acnt == ALARM_LAST)
                        state_n = IDLE;
                    else
                        acnt_n = acnt + 1'b1;
                end else begin
                    presc_n = presc + 1'b1;
                end
            end
            default: begin
                count_n = '0;
                presc_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            presc   <= '0;
            acnt    <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            presc   <= presc_n;
            acnt    <= acnt_n;
            running <= (state_n == RUN);
            alarm   <= (state_n == ALARM);
            tick    <= tick_n;
        end
    end

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with TICK_DIV=4, ALARM_SECS=3.
module tb_egg_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_start = 1'b0, btn_min = 1'b0, btn_sec = 1'b0, btn_clr = 1'b0;
    logic [11:0] count;
    logic        running, alarm, tick;

    int n_tests = 0;
    int n_fail  = 0;

    egg_timer_ctrl #(.TICK_DIV(4), .MAX_COUNT(3599), .ALARM_SECS(3)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_min(btn_min),
        .btn_sec(btn_sec), .btn_clr(btn_clr), .count(count),
        .running(running), .alarm(alarm), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s, m, sc, c;
        logic [11:0] cnt;
        logic        run, al, tk;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input int cnt, input logic run,
                           input logic al, input logic tk);
        chk({name, "_count"}, int'(count), cnt);
        chk({name, "_running"}, int'(running), int'(run));
        chk({name, "_alarm"}, int'(alarm), int'(al));
        chk({name, "_tick"}, int'(tick), int'(tk));
    endtask

    // Drive one cycle of button pulses, then sample 1 time unit after the edge
    task automatic step(input logic s, input logic m, input logic sc, input logic c);
        btn_start = s; btn_min = m; btn_sec = sc; btn_clr = c;
        @(posedge clk);
        #1;
        btn_start = 0; btn_min = 0; btn_sec = 0; btn_clr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic load(input int mins, input int secs);
        step(0, 0, 0, 1);
        for (int i = 0; i < mins; i++) step(0, 1, 0, 0);
        for (int i = 0; i < secs; i++) step(0, 0, 1, 0);
    endtask

    initial begin
        // start, min, sec, clr | count, running, alarm, tick
        tbl[0]  = '{1, 0, 0, 0,    0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0,   60, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0,   61, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0,  121, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 1,    0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 1,    0, 0, 0, 0};
        tbl[6]  = '{0, 0, 1, 0,    1, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0,    1, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,    1, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,    1, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 0,    1, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0,    0, 0, 1, 1};
        tbl[12] = '{0, 0, 1, 0,    0, 0, 0, 0};
        tbl[13] = '{0, 0, 1, 0,    1, 0, 0, 0};

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s, tbl[i].m, tbl[i].sc, tbl[i].c);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].cnt), tbl[i].run, tbl[i].al, tbl[i].tk);
        end

        // 1 min + 30 s
        load(1, 30);
        chk_all("set_90", 90, 0, 0, 0);

        // Count 2 to alarm, then alarm times out after 3 ticks
        load(0, 2);
        step(1, 0, 0, 0);
        chk_all("run2_start", 2, 1, 0, 0);
        idle(3);
        chk_all("run2_k3", 2, 1, 0, 0);
        idle(1);
        chk_all("run2_k4", 1, 1, 0, 1);
        idle(4);
        chk_all("run2_k8", 0, 0, 1, 1);
        idle(11);
        chk_all("run2_k19", 0, 0, 1, 0);
        idle(1);
        chk_all("run2_k20", 0, 0, 0, 1);
        step(0, 0, 1, 0);
        chk_all("after_alarm_idle", 1, 0, 0, 0);

        // Saturation at 59:59
        load(59, 59);
        chk_all("sat_3599", 3599, 0, 0, 0);
        step(0, 1, 0, 0);
        chk_all("sat_min", 3599, 0, 0, 0);
        step(0, 0, 1, 0);
        chk_all("sat_sec", 3599, 0, 0, 0);
        load(59, 30);
        chk_all("set_3570", 3570, 0, 0, 0);
        step(0, 1, 0, 0);
        chk_all("sat_3570_min", 3599, 0, 0, 0);

        // Pause keeps the partial second
        load(0, 5);
        step(1, 0, 0, 0);
        chk_all("p_start", 5, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0);
        chk_all("p_pause", 5, 0, 0, 0);
        idle(3);
        chk_all("p_held", 5, 0, 0, 0);
        step(0, 1, 0, 0);
        chk_all("p_edit", 65, 0, 0, 0);
        load(0, 5);
        step(1, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0);
        chk_all("p_resume", 5, 1, 0, 0);
        idle(1);
        chk_all("p_r1", 5, 1, 0, 0);
        idle(1);
        chk_all("p_r2", 4, 1, 0, 1);

        // Buttons in RUN: min/sec ignored, clr beats start
        load(0, 5);
        step(1, 0, 0, 0);
        idle(1);
        step(0, 1, 0, 0);
        chk_all("run_min", 5, 1, 0, 0);
        step(0, 0, 1, 0);
        chk_all("run_sec", 5, 1, 0, 0);
        step(1, 0, 0, 1);
        chk_all("run_clr_start", 0, 0, 0, 0);

        // Reset on the edge where an alarm tick would fire
        load(0, 1);
        step(1, 0, 0, 0);
        idle(4);
        chk_all("ra_alarm", 0, 0, 1, 1);
        idle(3);
        rst = 1;
        idle(1);
        chk_all("ra_reset", 0, 0, 0, 0);
        rst = 0;
        step(0, 0, 1, 0);
        chk_all("ra_after", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
